// File: rtl/i2c_mem_datapath.sv
// ---------------------------------------------------------------------------
// i2c_mem_datapath
//
// Purpose:
//   Memory address/data path that sits behind the I2C memory control FSM.
//   It turns the FSM's per-state control levels into RAM traffic. The block
//   owns the RAM address pointer and stages received write bytes. It issues
//   single-cycle RAM write/read strobes. Fetched bytes go to the transmit
//   shifter through a valid/taken handshake.
//
// Parameters:
//   ADDR_W     - RAM address width (<= 8); the address byte supplies rx_byte[ADDR_W-1:0]
//   RAM_RD_LAT - RAM read latency from ram_re to ram_rdata valid (1 or 2)
//
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   rx_byte, rx_byte_valid     - received byte and its one-cycle completion pulse
//   read_mem_address           - level: control FSM in address-byte state
//   write_mem                  - level: control FSM in write-data state
//   wren                       - level: control FSM in write-commit state
//   increment_mem_address      - level: control FSM in an increment state
//   read_mem                   - level: control FSM in read-data state
//   ram_addr, ram_wdata        - RAM address (current pointer) and write data
//   ram_we, ram_re             - single-cycle RAM write / read strobes
//   ram_rdata                  - RAM read data
//   tx_byte, tx_byte_valid     - fetched byte for the transmit shifter, valid flag
//   tx_byte_taken              - one-cycle pulse: shifter loaded tx_byte
//   addr_overflow              - sticky address saturation flag
//
// Build option:
//   I2C_MEM_ADDR_SATURATE_EN - when defined, the pointer saturates at its top
//   value and sets addr_overflow. Otherwise it wraps and addr_overflow is 0.
// ---------------------------------------------------------------------------
module i2c_mem_datapath #(
  parameter int ADDR_W     = 8,
  parameter int RAM_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_byte,
  input  logic              rx_byte_valid,
  input  logic              read_mem_address,
  input  logic              write_mem,
  input  logic              wren,
  input  logic              increment_mem_address,
  input  logic              read_mem,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [7:0]        ram_rdata,
  output logic [7:0]        tx_byte,
  output logic              tx_byte_valid,
  input  logic              tx_byte_taken,
  output logic              addr_overflow
);

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ISSUE,
    RD_WAIT,
    RD_HOLD
  } rd_state_e;

  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
  localparam logic [1:0]        LAT_LAST = 2'(RAM_RD_LAT - 1);

  rd_state_e         rd_state_q, rd_state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              wdata_pending_q, wdata_pending_d;
  logic              ram_we_q, ram_we_d;
  logic              ram_re_q, ram_re_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              tx_byte_valid_q, tx_byte_valid_d;
  logic [1:0]        lat_cnt_q, lat_cnt_d;
  logic              wren_prev_q, wren_prev_d;
  logic              inc_prev_q, inc_prev_d;
  logic              rd_prev_q, rd_prev_d;

  logic              addr_load;
  logic              wren_edge;
  logic              inc_edge;
  logic              rd_edge;

`ifdef I2C_MEM_ADDR_SATURATE_EN
  logic              overflow_q, overflow_d;
`endif

  // The control inputs are state levels. Registered copies turn them into
  // rising-edge events, so a level held for several cycles acts only once.
  assign addr_load = rx_byte_valid && read_mem_address;
  assign wren_edge = wren && !wren_prev_q;
  assign inc_edge  = increment_mem_address && !inc_prev_q;
  assign rd_edge   = read_mem && !rd_prev_q;

  // Next-state logic for the pointer, write staging and read FSM. The strobes
  // are registered, so each strobe is high in the cycle after its triggering
  // edge. A write strobe therefore always sees the pointer before any
  // increment sampled in that same cycle.
  always_comb begin
    rd_state_d      = rd_state_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    wdata_pending_d = wdata_pending_q;
    ram_we_d        = 1'b0;
    ram_re_d        = 1'b0;
    tx_byte_d       = tx_byte_q;
    tx_byte_valid_d = tx_byte_valid_q;
    lat_cnt_d       = lat_cnt_q;
    wren_prev_d     = wren;
    inc_prev_d      = increment_mem_address;
    rd_prev_d       = read_mem;
`ifdef I2C_MEM_ADDR_SATURATE_EN
    overflow_d      = overflow_q;
`endif

    // A new address byte has priority over an increment.
    if (addr_load) begin
      addr_d = rx_byte[ADDR_W-1:0];
`ifdef I2C_MEM_ADDR_SATURATE_EN
      overflow_d = 1'b0;
`endif
    end else if (inc_edge) begin
`ifdef I2C_MEM_ADDR_SATURATE_EN
      if (addr_q == ADDR_MAX) begin
        overflow_d = 1'b1;
      end else begin
        addr_d = addr_q + 1'b1;
      end
`else
      addr_d = addr_q + 1'b1;
`endif
    end

    // One write per staged byte: the commit consumes the pending flag.
    if (wren_edge && wdata_pending_q) begin
      ram_we_d        = 1'b1;
      wdata_pending_d = 1'b0;
    end
    if (rx_byte_valid && write_mem) begin
      wdata_d         = rx_byte;
      wdata_pending_d = 1'b1;
    end

    case (rd_state_q)
      RD_IDLE: begin
        if (rd_edge) begin
          rd_state_d = RD_ISSUE;
          ram_re_d   = 1'b1;
        end
      end
      RD_ISSUE: begin
        rd_state_d = RD_WAIT;
        lat_cnt_d  = 2'd0;
      end
      RD_WAIT: begin
        if (lat_cnt_q == LAT_LAST) begin
          // A byte that arrives after read_mem has dropped is discarded.
          if (read_mem) begin
            tx_byte_d       = ram_rdata;
            tx_byte_valid_d = 1'b1;
            rd_state_d      = RD_HOLD;
          end else begin
            rd_state_d = RD_IDLE;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + 2'd1;
        end
      end
      RD_HOLD: begin
        if (tx_byte_taken) begin
          tx_byte_valid_d = 1'b0;
          rd_state_d      = RD_IDLE;
        end
      end
      default: begin
        rd_state_d = RD_IDLE;
      end
    endcase

    // Loading a new address discards any read in flight for the old one.
    if (addr_load) begin
      tx_byte_valid_d = 1'b0;
      rd_state_d      = RD_IDLE;
      ram_re_d        = 1'b0;
    end
  end

  // State register. The reset is asynchronous so strobes drop immediately.
  // Any staged write byte is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q      <= RD_IDLE;
      addr_q          <= '0;
      wdata_q         <= '0;
      wdata_pending_q <= 1'b0;
      ram_we_q        <= 1'b0;
      ram_re_q        <= 1'b0;
      tx_byte_q       <= '0;
      tx_byte_valid_q <= 1'b0;
      lat_cnt_q       <= '0;
      wren_prev_q     <= 1'b0;
      inc_prev_q      <= 1'b0;
      rd_prev_q       <= 1'b0;
`ifdef I2C_MEM_ADDR_SATURATE_EN
      overflow_q      <= 1'b0;
`endif
    end else begin
      rd_state_q      <= rd_state_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      wdata_pending_q <= wdata_pending_d;
      ram_we_q        <= ram_we_d;
      ram_re_q        <= ram_re_d;
      tx_byte_q       <= tx_byte_d;
      tx_byte_valid_q <= tx_byte_valid_d;
      lat_cnt_q       <= lat_cnt_d;
      wren_prev_q     <= wren_prev_d;
      inc_prev_q      <= inc_prev_d;
      rd_prev_q       <= rd_prev_d;
`ifdef I2C_MEM_ADDR_SATURATE_EN
      overflow_q      <= overflow_d;
`endif
    end
  end

  assign ram_addr      = addr_q;
  assign ram_wdata     = wdata_q;
  assign ram_we        = ram_we_q;
  assign ram_re        = ram_re_q;
  assign tx_byte       = tx_byte_q;
  assign tx_byte_valid = tx_byte_valid_q;

`ifdef I2C_MEM_ADDR_SATURATE_EN
  assign addr_overflow = overflow_q;
`else
  assign addr_overflow = 1'b0;
`endif

  // The control FSM never sits in a write and a read state together.
  // As a result, the two RAM strobes must never overlap.
  strobe_exclusive_a : assert property (@(posedge clk) disable iff (!rst_n)
    !(ram_we_q && ram_re_q));

endmodule

// File: tb/tb_i2c_mem_datapath.sv
module tb_i2c_mem_datapath;

  localparam int ADDR_W = 8;
  localparam int LAT    = 2;

  logic              clk;
  logic              rst_n;
  logic [7:0]        rx_byte;
  logic              rx_byte_valid;
  logic              read_mem_address;
  logic              write_mem;
  logic              wren;
  logic              increment_mem_address;
  logic              read_mem;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic              ram_we;
  logic              ram_re;
  logic [7:0]        ram_rdata;
  logic [7:0]        tx_byte;
  logic              tx_byte_valid;
  logic              tx_byte_taken;
  logic              addr_overflow;

  int total = 0;
  int bad   = 0;

  // Bench-side RAM with LAT-cycle registered read, plus a write-strobe monitor.
  logic [7:0] mem [0:255];
  logic [7:0] rd1, rd2;
  int         we_count = 0;
  logic [7:0] we_addr, we_data;

  i2c_mem_datapath #(.ADDR_W(ADDR_W), .RAM_RD_LAT(LAT)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .rx_byte               (rx_byte),
    .rx_byte_valid         (rx_byte_valid),
    .read_mem_address      (read_mem_address),
    .write_mem             (write_mem),
    .wren                  (wren),
    .increment_mem_address (increment_mem_address),
    .read_mem              (read_mem),
    .ram_addr              (ram_addr),
    .ram_wdata             (ram_wdata),
    .ram_we                (ram_we),
    .ram_re                (ram_re),
    .ram_rdata             (ram_rdata),
    .tx_byte               (tx_byte),
    .tx_byte_valid         (tx_byte_valid),
    .tx_byte_taken         (tx_byte_taken),
    .addr_overflow         (addr_overflow)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: writes on the strobe, reads through a LAT-deep pipeline.
  always @(posedge clk) begin
    if (ram_we === 1'b1) mem[ram_addr] <= ram_wdata;
    if (ram_re === 1'b1) rd1 <= mem[ram_addr];
    rd2 <= rd1;
  end
  assign ram_rdata = (LAT == 1) ? rd1 : rd2;

  // Record every write strobe the RAM sees.
  always @(posedge clk) begin
    if (ram_we === 1'b1) begin
      we_count <= we_count + 1;
      we_addr  <= ram_addr;
      we_data  <= ram_wdata;
    end
  end

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_addr(input logic [7:0] b);
    rx_byte = b; read_mem_address = 1'b1; rx_byte_valid = 1'b1;
    tick();
    rx_byte_valid = 1'b0; read_mem_address = 1'b0;
  endtask

  task automatic send_data(input logic [7:0] b);
    rx_byte = b; write_mem = 1'b1; rx_byte_valid = 1'b1;
    tick();
    rx_byte_valid = 1'b0; write_mem = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; rx_byte = 8'h00; rx_byte_valid = 1'b0; read_mem_address = 1'b0;
    write_mem = 1'b0; wren = 1'b0; increment_mem_address = 1'b0; read_mem = 1'b0;
    tx_byte_taken = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({ram_addr, ram_wdata, ram_we, ram_re, tx_byte, tx_byte_valid, addr_overflow} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got addr=%h wd=%h we=%b re=%b tx=%h v=%b ov=%b want all 0",
               ram_addr, ram_wdata, ram_we, ram_re, tx_byte, tx_byte_valid, addr_overflow);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_single();
    int start;
    start = we_count;
    send_addr(8'h10);
    total++;
    if (ram_addr !== 8'h10) begin bad++; $display("[TB] FAIL load_addr: got %h want 10", ram_addr); end
    send_data(8'hA5);
    total++;
    if (ram_we !== 1'b0) begin bad++; $display("[TB] FAIL we_before_wren: got %b want 0", ram_we); end
    wren = 1'b1;
    tick();
    total++;
    if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 8'h10, 8'hA5}) begin
      bad++; $display("[TB] FAIL write_strobe: got we=%b a=%h d=%h want we=1 a=10 d=a5", ram_we, ram_addr, ram_wdata);
    end
    tick();
    total++;
    if (ram_we !== 1'b0) begin bad++; $display("[TB] FAIL write_one_cycle: got %b want 0", ram_we); end
    tick();
    wren = 1'b0;
    tick();
    total++;
    if (we_count - start !== 1 || we_addr !== 8'h10 || we_data !== 8'hA5) begin
      bad++; $display("[TB] FAIL write_single_count: got n=%0d a=%h d=%h want n=1 a=10 d=a5", we_count - start, we_addr, we_data);
    end
    // A second wren edge with nothing staged must not write.
    start = we_count;
    wren = 1'b1; tick(); tick(); wren = 1'b0; tick();
    total++;
    if (we_count - start !== 0) begin bad++; $display("[TB] FAIL write_no_pending: got %0d writes want 0", we_count - start); end
  endtask

  task automatic test_burst_write();
    int start;
    logic [7:0] exp_a;
    start = we_count;
    send_addr(8'h20);
    for (int i = 1; i <= 3; i++) begin
      exp_a = 8'h1F + 8'(i);
      send_data(8'(i));
      wren = 1'b1;
      tick();
      total++;
      if ({ram_we, ram_addr, ram_wdata} !== {1'b1, exp_a, 8'(i)}) begin
        bad++; $display("[TB] FAIL burst_write_%0d: got we=%b a=%h d=%h want we=1 a=%h d=%h", i, ram_we, ram_addr, ram_wdata, exp_a, 8'(i));
      end
      // Increment edge arrives while the write strobe is still high.
      wren = 1'b0; increment_mem_address = 1'b1;
      tick();
      total++;
      if (ram_addr !== exp_a + 8'h01) begin bad++; $display("[TB] FAIL burst_incr_%0d: got %h want %h", i, ram_addr, exp_a + 8'h01); end
      tick();
      increment_mem_address = 1'b0;
      tick();
    end
    total++;
    if (ram_addr !== 8'h23 || we_count - start !== 3) begin
      bad++; $display("[TB] FAIL burst_end: got a=%h n=%0d want a=23 n=3", ram_addr, we_count - start);
    end
    total++;
    if ({mem[8'h20], mem[8'h21], mem[8'h22]} !== 24'h010203) begin
      bad++; $display("[TB] FAIL burst_mem: got %h %h %h want 01 02 03", mem[8'h20], mem[8'h21], mem[8'h22]);
    end
  endtask

  task automatic test_read();
    send_addr(8'h05); send_data(8'h3C);
    wren = 1'b1; tick(); wren = 1'b0; tick();
    send_addr(8'h05);
    read_mem = 1'b1;
    tick();
    total++;
    if ({ram_re, ram_addr, ram_we} !== {1'b1, 8'h05, 1'b0}) begin
      bad++; $display("[TB] FAIL read_strobe: got re=%b a=%h we=%b want re=1 a=05 we=0", ram_re, ram_addr, ram_we);
    end
    tick();
    total++;
    if (ram_re !== 1'b0) begin bad++; $display("[TB] FAIL read_one_cycle: got %b want 0", ram_re); end
    tick();
    total++;
    if (tx_byte_valid !== 1'b0) begin bad++; $display("[TB] FAIL read_early: got %b want 0", tx_byte_valid); end
    tick();
    total++;
    if ({tx_byte_valid, tx_byte} !== {1'b1, 8'h3C}) begin
      bad++; $display("[TB] FAIL read_data: got v=%b tx=%h want v=1 tx=3c", tx_byte_valid, tx_byte);
    end
    tick(); tick();
    total++;
    if (tx_byte_valid !== 1'b1) begin bad++; $display("[TB] FAIL read_hold: got %b want 1", tx_byte_valid); end
    tx_byte_taken = 1'b1; tick(); tx_byte_taken = 1'b0;
    total++;
    if (tx_byte_valid !== 1'b0) begin bad++; $display("[TB] FAIL read_taken: got %b want 0", tx_byte_valid); end
    read_mem = 1'b0;
    tick();
  endtask

  task automatic test_read_abort();
    read_mem = 1'b1;
    tick(); tick();
    read_mem = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (tx_byte_valid !== 1'b0) begin bad++; $display("[TB] FAIL abort_valid_%0d: got %b want 0", i, tx_byte_valid); end
    end
    // A fresh read starts with exact timing only if the FSM is back in idle.
    read_mem = 1'b1;
    tick();
    total++;
    if (ram_re !== 1'b1) begin bad++; $display("[TB] FAIL abort_idle_re: got %b want 1", ram_re); end
    tick(); tick(); tick();
    total++;
    if ({tx_byte_valid, tx_byte} !== {1'b1, 8'h3C}) begin
      bad++; $display("[TB] FAIL abort_reread: got v=%b tx=%h want v=1 tx=3c", tx_byte_valid, tx_byte);
    end
    tx_byte_taken = 1'b1; tick(); tx_byte_taken = 1'b0; read_mem = 1'b0; tick();
  endtask

  task automatic test_wrap();
    logic [7:0] exp_a;
    logic       exp_ov;
`ifdef I2C_MEM_ADDR_SATURATE_EN
    exp_a = 8'hFF; exp_ov = 1'b1;
`else
    exp_a = 8'h00; exp_ov = 1'b0;
`endif
    send_addr(8'hFF);
    increment_mem_address = 1'b1; tick(); increment_mem_address = 1'b0; tick();
    total++;
    if ({ram_addr, addr_overflow} !== {exp_a, exp_ov}) begin
      bad++; $display("[TB] FAIL wrap_incr: got a=%h ov=%b want a=%h ov=%b", ram_addr, addr_overflow, exp_a, exp_ov);
    end
    send_addr(8'h00);
    total++;
    if ({ram_addr, addr_overflow} !== {8'h00, 1'b0}) begin
      bad++; $display("[TB] FAIL wrap_reload: got a=%h ov=%b want a=00 ov=0", ram_addr, addr_overflow);
    end
  endtask

  task automatic test_reset_midop();
    int start;
    send_addr(8'h30); send_data(8'h77);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({ram_addr, ram_wdata, ram_we, ram_re, tx_byte_valid} !== '0) begin
      bad++; $display("[TB] FAIL midwrite_reset: got a=%h wd=%h we=%b re=%b v=%b want all 0", ram_addr, ram_wdata, ram_we, ram_re, tx_byte_valid);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    start = we_count;
    wren = 1'b1; tick(); tick(); wren = 1'b0; tick();
    total++;
    if (we_count - start !== 0) begin bad++; $display("[TB] FAIL lost_write: got %0d writes want 0", we_count - start); end
    // Reset while the read strobe is high must drop it at once.
    read_mem = 1'b1;
    tick();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({ram_re, tx_byte_valid} !== 2'b00) begin bad++; $display("[TB] FAIL midread_reset: got re=%b v=%b want 0 0", ram_re, tx_byte_valid); end
    read_mem = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    total++;
    if (tx_byte_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_read_idle: got %b want 0", tx_byte_valid); end
  endtask

  initial begin
    test_reset();
    test_write_single();
    test_burst_write();
    test_read();
    test_read_abort();
    test_wrap();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the run always ends on its own.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish want finish before 200000 ns");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/i2c_mem_datapath.md
Name: i2c_mem_datapath

Overview:
Memory address/data path downstream of the I2C memory control state machine. Consumes its per-state control levels: read_mem_address, write_mem, wren, increment_mem_address and read_mem. Owns the memory address pointer, stages received write bytes, and issues single-cycle RAM write and read strobes. Presents fetched RAM bytes to the I2C transmit shifter through a valid/taken handshake.

Parameters:
ADDR_W, 8, RAM address width; address byte uses rx_byte[ADDR_W-1:0], ADDR_W <= 8
RAM_RD_LAT, 1, RAM read latency in clk cycles from ram_re to ram_rdata valid (1 or 2)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
rx_byte  input  8  byte assembled by the I2C receive shifter
rx_byte_valid  input  1  one-cycle pulse: rx_byte complete
read_mem_address  input  1  level: control FSM in address-byte state
write_mem  input  1  level: control FSM in write-data state
wren  input  1  level: control FSM in write-commit (ACK_3) state
increment_mem_address  input  1  level: control FSM in an increment state
read_mem  input  1  level: control FSM in read-data state
ram_addr  output  ADDR_W  RAM address (always the current pointer)
ram_wdata  output  8  RAM write data
ram_we  output  1  RAM write strobe
ram_re  output  1  RAM read strobe
ram_rdata  input  8  RAM read data
tx_byte  output  8  byte for the transmit shifter
tx_byte_valid  output  1  tx_byte holds fresh data
tx_byte_taken  input  1  one-cycle pulse: shifter loaded tx_byte
addr_overflow  output  1  sticky saturation flag (see Optional Feature)

Behaviour:
- Reset is asynchronous. All registers clear to 0: addr, wdata_reg, wdata_pending, ram_we, ram_re, tx_byte, tx_byte_valid, addr_overflow. Read FSM resets to RD_IDLE.
- The block keeps registered copies of wren, increment_mem_address and read_mem for rising-edge detection. These also reset to 0.
- Address load: rx_byte_valid && read_mem_address -> addr <= rx_byte[ADDR_W-1:0] on the next edge.
  - The same load flushes the read path: tx_byte_valid <= 0 and the read FSM goes to RD_IDLE.
- Write staging: rx_byte_valid && write_mem -> wdata_reg <= rx_byte and wdata_pending <= 1.
- Write commit: rising edge of wren with wdata_pending=1 -> ram_we=1 for exactly one cycle.
  - During that cycle ram_wdata=wdata_reg and ram_addr=addr. wdata_pending clears.
  - A multi-cycle wren produces one write only.
  - A wren edge with wdata_pending=0 produces no write.
- Increment: rising edge of increment_mem_address -> addr <= addr+1 modulo 2^ADDR_W. One increment per edge.
- Simultaneous write strobe and increment edge: the write uses the pre-increment address. The new address appears the cycle after.
- Read FSM states: RD_IDLE, RD_ISSUE, RD_WAIT, RD_HOLD.
  - RD_IDLE: rising edge of read_mem -> RD_ISSUE.
  - RD_ISSUE: ram_re=1 for one cycle at addr -> RD_WAIT.
  - RD_WAIT: counts RAM_RD_LAT cycles, then captures ram_rdata into tx_byte.
    - If read_mem is still 1: tx_byte_valid<=1 -> RD_HOLD.
    - If read_mem has fallen (NACK/stop): the byte is discarded, tx_byte_valid stays 0 -> RD_IDLE.
  - RD_HOLD: tx_byte_taken -> tx_byte_valid<=0 -> RD_IDLE.
- Read latency: tx_byte_valid rises exactly RAM_RD_LAT+2 cycles after the read_mem rising edge.
- tx_byte_taken while tx_byte_valid=0 is ignored.
- A read_mem rising edge outside RD_IDLE is ignored.
- ram_we and ram_re are never high in the same cycle. The control FSM write and read states are mutually exclusive; a verification assertion checks this.
- Reset mid-operation: all strobes drop immediately, any pending write is lost, and the read FSM returns to RD_IDLE.

Optional Feature:
Macro I2C_MEM_ADDR_SATURATE_EN.
- Defined:
  - An increment edge at addr = 2^ADDR_W-1 leaves addr unchanged and sets addr_overflow=1.
  - addr_overflow stays 1 until the next address load or reset.
  - Writes and reads at the saturated address still occur.
- Undefined:
  - addr wraps to 0.
  - addr_overflow is tied to 0.

Test Plan:
- Address load then write: rx 0x10 with read_mem_address, rx 0xA5 with write_mem, wren pulse for 3 cycles -> single ram_we with addr 0x10, wdata 0xA5.
- Burst write: load 0x20, then the sequence (data, wren, increment) x3 with 0x01, 0x02, 0x03 -> writes to 0x20, 0x21, 0x22; addr ends at 0x23.
- Read with RAM_RD_LAT=2: load 0x05, RAM[0x05]=0x3C, read_mem rises -> ram_re one cycle at 0x05; tx_byte=0x3C with tx_byte_valid 4 cycles after the edge; cleared by tx_byte_taken.
- Read abort: read_mem falls during RD_WAIT -> tx_byte_valid stays 0 and the FSM is in RD_IDLE.
- Wrap/saturate: load 0xFF, increment edge -> addr=0x00 without the macro; with the macro, addr stays 0xFF and addr_overflow=1, cleared by a new load of 0x00.
- Async reset asserted mid-write (wdata_pending=1) -> no ram_we after release; all outputs 0.
